// File: rtl/lsio_timer_alarm.sv
// Alarm stage behind the LSIO ms timer: compares the ms count against a
// programmable compare value and raises a registered level interrupt.
module lsio_timer_alarm #(
   parameter logic [31:0] CMP_RESET    = 32'h0000_0000,
   parameter logic [31:0] PERIOD_RESET = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] time_i,
   input  logic        tick_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        irq_o
);

   localparam logic [1:0] ADDR_TIME   = 2'd0;
   localparam logic [1:0] ADDR_CMP    = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   logic [31:0] cmp_q, cmp_d;
   logic [31:0] period_q, period_d;
   logic        en_q, en_d;
   logic        periodic_q, periodic_d;
   logic        irq_en_q, irq_en_d;
   logic        pend_q, pend_d;
   logic        ovr_q, ovr_d;
   logic        tick_q;
   logic        ack_q;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q, irq_d;

   logic        wr_cmp, wr_period, wr_ctrl;
   logic        clr_pend, clr_ovr;
   logic        fire;
   logic [31:0] delta;
   logic [31:0] ctrl_view;
   logic [31:0] rd_sel;

   // Next-state evaluation: bus decode, compare, and collision priorities
   always_comb begin
      wr_cmp    = req_i & we_i & (addr_i[3:2] == ADDR_CMP);
      wr_period = req_i & we_i & (addr_i[3:2] == ADDR_PERIOD);
      wr_ctrl   = req_i & we_i & (addr_i[3:2] == ADDR_CTRL);
      clr_pend  = wr_ctrl & wdata_i[8];
      clr_ovr   = wr_ctrl & wdata_i[9];

      // Sign bit of the difference gives a wrap-safe "time has reached CMP"
      delta = time_i - cmp_q;
      fire  = tick_q & en_q & ~delta[31];

      ctrl_view = {22'd0, ovr_q, pend_q, 5'd0, irq_en_q, periodic_q, en_q};

      if (wr_cmp) begin
         cmp_d = wdata_i;
      end else if (fire & periodic_q & (period_q != 32'd0)) begin
         cmp_d = cmp_q + period_q;
      end else begin
         cmp_d = cmp_q;
      end

      if (wr_period) begin
         period_d = wdata_i;
      end else begin
         period_d = period_q;
      end

      if (wr_ctrl) begin
         en_d       = wdata_i[0];
         periodic_d = wdata_i[1];
         irq_en_d   = wdata_i[2];
      end else if (fire & (~periodic_q | (period_q == 32'd0))) begin
         en_d       = 1'b0;
         periodic_d = periodic_q;
         irq_en_d   = irq_en_q;
      end else begin
         en_d       = en_q;
         periodic_d = periodic_q;
         irq_en_d   = irq_en_q;
      end

      if (fire) begin
         pend_d = 1'b1;
      end else if (clr_pend) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end

      // A fire on top of an uncleared event is an overrun; a same-cycle W1C absorbs it
      if (fire & pend_q & ~clr_pend) begin
         ovr_d = 1'b1;
      end else if (clr_ovr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end

      irq_d = pend_d & irq_en_d;

      case (addr_i[3:2])
         ADDR_TIME:   rd_sel = time_i;
         ADDR_CMP:    rd_sel = cmp_q;
         ADDR_PERIOD: rd_sel = period_q;
         ADDR_CTRL:   rd_sel = ctrl_view;
         default:     rd_sel = 32'd0;
      endcase

      if (req_i & ~we_i) begin
         rdata_d = rd_sel;
      end else begin
         rdata_d = 32'd0;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cmp_q      <= CMP_RESET;
         period_q   <= PERIOD_RESET;
         en_q       <= 1'b0;
         periodic_q <= 1'b0;
         irq_en_q   <= 1'b0;
         pend_q     <= 1'b0;
         ovr_q      <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         rdata_q    <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         cmp_q      <= cmp_d;
         period_q   <= period_d;
         en_q       <= en_d;
         periodic_q <= periodic_d;
         irq_en_q   <= irq_en_d;
         pend_q     <= pend_d;
         ovr_q      <= ovr_d;
         tick_q     <= tick_i;
         ack_q      <= req_i;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign ack_o   = ack_q;
   assign rdata_o = rdata_q;
   assign irq_o   = irq_q;

endmodule

// File: tb/tb_lsio_timer_alarm.sv
// Scoreboard bench for lsio_timer_alarm: a cycle-level reference model predicts
// read data, ack and irq; a negedge monitor pops and compares.
module tb_lsio_timer_alarm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = 4'd0;
   logic [31:0] tval = 32'h0000_1234;
   logic [31:0] wdata = 32'd0;
   logic        ack;
   logic [31:0] rdata;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   logic [31:0] m_cmp, m_per;
   bit          m_en, m_pm, m_ie, m_pend, m_ovr, m_tq, m_ack, m_irq;
   bit          dir_use = 1'b0;
   logic [31:0] dir_exp = 32'd0;
   string       dir_tag = "";

   lsio_timer_alarm dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .time_i  (tval),
      .tick_i  (tick),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
      .ack_o   (ack),
      .rdata_o (rdata),
      .irq_o   (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cmp = 32'd0; m_per = 32'd0;
      m_en = 0; m_pm = 0; m_ie = 0; m_pend = 0; m_ovr = 0;
      m_tq = 0; m_ack = 0; m_irq = 0;
      exp_q.delete();
      tag_q.delete();
   endtask

   // One clock of the reference model, applied from the inputs about to be sampled
   task automatic model_step();
      logic [31:0] ctrl, rd, n_cmp, n_per;
      bit fire, ctrl_wr, w1c_p, w1c_o;
      bit n_en, n_pm, n_ie, n_pend, n_ovr;
      if (rst) begin
         model_reset();
         return;
      end
      ctrl = {22'd0, m_ovr, m_pend, 5'd0, m_ie, m_pm, m_en};
      fire = m_tq && m_en && ((tval - m_cmp) < 32'h8000_0000);
      if (req) begin
         if (we) begin
            exp_q.push_back(32'd0); tag_q.push_back("wr_rdata");
         end else if (dir_use) begin
            exp_q.push_back(dir_exp); tag_q.push_back(dir_tag);
         end else begin
            case (addr[3:2])
               2'd0:    rd = tval;
               2'd1:    rd = m_cmp;
               2'd2:    rd = m_per;
               default: rd = ctrl;
            endcase
            exp_q.push_back(rd); tag_q.push_back("rnd_read");
         end
      end
      ctrl_wr = req && we && (addr[3:2] == 2'd3);
      w1c_p = ctrl_wr && wdata[8];
      w1c_o = ctrl_wr && wdata[9];
      n_cmp = m_cmp; n_per = m_per; n_en = m_en; n_pm = m_pm; n_ie = m_ie;
      n_pend = m_pend; n_ovr = m_ovr;
      if (w1c_p) n_pend = 0;
      if (w1c_o) n_ovr = 0;
      if (fire) begin
         if (m_pend && !w1c_p) n_ovr = 1;
         n_pend = 1;
         if (!m_pm || m_per == 32'd0) n_en = 0;
         else n_cmp = m_cmp + m_per;
      end
      if (req && we && addr[3:2] == 2'd1) n_cmp = wdata;
      if (req && we && addr[3:2] == 2'd2) n_per = wdata;
      if (ctrl_wr) begin
         n_en = wdata[0]; n_pm = wdata[1]; n_ie = wdata[2];
      end
      m_cmp = n_cmp; m_per = n_per; m_en = n_en; m_pm = n_pm; m_ie = n_ie;
      m_pend = n_pend; m_ovr = n_ovr;
      m_tq = tick; m_ack = req; m_irq = n_pend && n_ie;
   endtask

   // Monitor: compare ack/irq every cycle and pop read data on each ack
   always @(negedge clk) begin
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      if (ack) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got ack with no expected entry");
         end else begin
            chk(tag_q.pop_front(), rdata, exp_q.pop_front());
         end
      end else begin
         chk("rdata_idle", rdata, 32'd0);
      end
   end

   task automatic cycle();
      @(negedge clk); #1;
      model_step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      req = 1; we = 1; addr = a; wdata = d;
      cycle();
      req = 0; we = 0;
   endtask

   task automatic rd_exp(input logic [3:0] a, input logic [31:0] e, input string nm);
      dir_use = 1; dir_exp = e; dir_tag = nm;
      req = 1; we = 0; addr = a;
      cycle();
      req = 0; dir_use = 0;
   endtask

   task automatic rd_model(input logic [3:0] a);
      req = 1; we = 0; addr = a;
      cycle();
      req = 0;
   endtask

   task automatic ms();
      tick = 1; cycle(); tick = 0; tval = tval + 32'd1; cycle();
   endtask

   task automatic ms_with_write(input logic [3:0] a, input logic [31:0] d);
      tick = 1; cycle(); tick = 0; tval = tval + 32'd1;
      req = 1; we = 1; addr = a; wdata = d;
      cycle();
      req = 0; we = 0;
   endtask

   initial begin
      model_reset();
      cycle(); cycle();
      rst = 0;
      cycle();
      // reset values
      rd_exp(4'hC, 32'd0, "rst_ctrl");
      rd_exp(4'h4, 32'd0, "rst_cmp");
      rd_exp(4'h8, 32'd0, "rst_period");
      rd_exp(4'h0, 32'h0000_1234, "rst_time");

      // one-shot
      tval = 32'd0;
      wr(4'h4, 32'd5); wr(4'hC, 32'h5);
      repeat (5) ms();
      rd_exp(4'hC, 32'h104, "oneshot_ctrl");
      wr(4'hC, 32'h104);
      repeat (5) ms();
      rd_exp(4'hC, 32'h4, "oneshot_nofire");

      // periodic with software clear after each fire
      tval = 32'd8;
      wr(4'h8, 32'd3); wr(4'h4, 32'd10); wr(4'hC, 32'h7);
      while (tval != 32'd16) begin
         ms();
         if (m_pend && tval != 32'd16) wr(4'hC, 32'h107);
      end
      rd_exp(4'h4, 32'd19, "periodic_cmp");
      rd_exp(4'hC, 32'h107, "periodic_ctrl");

      // overrun
      wr(4'hC, 32'h300);
      tval = 32'd20;
      wr(4'h8, 32'd2); wr(4'h4, 32'd22); wr(4'hC, 32'h7);
      repeat (4) ms();
      rd_exp(4'hC, 32'h307, "overrun_set");
      wr(4'hC, 32'h307);
      rd_exp(4'hC, 32'h7, "overrun_clr");
      wr(4'hC, 32'h0);

      // wrap one-shot
      wr(4'h4, 32'hFFFF_FFFE);
      tval = 32'hFFFF_FFFC;
      wr(4'hC, 32'h5);
      repeat (5) ms();
      rd_exp(4'hC, 32'h104, "wrap_single");
      wr(4'hC, 32'h100);

      // wrap periodic reload
      tval = 32'hFFFF_FFFD;
      wr(4'h4, 32'hFFFF_FFFE); wr(4'h8, 32'd4); wr(4'hC, 32'h7);
      ms();
      rd_exp(4'h4, 32'h0000_0002, "wrap_reload");
      wr(4'hC, 32'h300);

      // compare already in the past
      tval = 32'd200;
      wr(4'h4, 32'd100); wr(4'hC, 32'h5);
      rd_exp(4'hC, 32'h5, "past_before");
      ms();
      rd_exp(4'hC, 32'h104, "past_fire");
      wr(4'hC, 32'h300);

      // W1C of PENDING on a fire cycle
      tval = 32'd300;
      wr(4'h8, 32'd1); wr(4'h4, 32'd301); wr(4'hC, 32'h7);
      ms();
      ms_with_write(4'hC, 32'h107);
      rd_exp(4'hC, 32'h107, "coll_w1c");
      wr(4'hC, 32'h300);

      // CTRL write on a one-shot fire cycle
      tval = 32'd398;
      wr(4'h4, 32'd400); wr(4'hC, 32'h5);
      ms();
      ms_with_write(4'hC, 32'h5);
      rd_exp(4'hC, 32'h105, "coll_en");

      // asynchronous reset with irq high and a tick_q in flight
      tick = 1; cycle(); tick = 0; tval = tval + 32'd1;
      #1 rst = 1; model_reset();
      #1 chk("async_irq", {31'd0, irq}, 32'd0);
      cycle();
      rst = 0;
      cycle();
      rd_exp(4'hC, 32'd0, "post_rst_ctrl");
      rd_exp(4'h4, 32'd0, "post_rst_cmp");

      // randomized traffic against the model
      tval = $urandom;
      for (int i = 0; i < 1500; i++) begin
         int r;
         logic [1:0] sel;
         logic [31:0] d;
         r = $urandom_range(0, 9);
         sel = 2'($urandom);
         case (sel)
            2'd1:    d = tval + 32'($urandom_range(0, 20)) - 32'd5;
            2'd2:    d = 32'($urandom_range(0, 6));
            default: d = $urandom;
         endcase
         if (r < 3) begin
            ms();
         end else if (r < 5) begin
            rd_model({sel, 2'($urandom)});
         end else if (r < 7) begin
            if (sel == 2'd3 && $urandom_range(0, 1) == 0) d = d & 32'hFFFF_FCFF;
            wr({sel, 2'($urandom)}, d);
         end else if (r == 7) begin
            ms_with_write({sel, 2'($urandom)}, d);
         end else begin
            if ($urandom_range(0, 30) == 0) tval = tval + 32'($urandom_range(0, 50));
            cycle();
         end
      end
      cycle(); cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expect: got %0d unconsumed entries expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsio_timer_alarm.md
Name: lsio_timer_alarm

Overview:
Programmable alarm/interrupt stage directly downstream of the LSIO millisecond timer. Consumes the free-running ms count and the one-ms tick. Compares the count against a software-written compare value and raises a level interrupt. Supports one-shot and periodic (auto-reload) modes, behind a small word-addressed register port on the LSIO bus.

Parameters:
CMP_RESET, 32'h0000_0000, reset value of CMP register
PERIOD_RESET, 32'h0000_0000, reset value of PERIOD register

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
time_i  input  32  ms count from LSIO timer; increments on cycle after tick_i
tick_i  input  1  one-ms event from LSIO timer, single-cycle pulse
req_i  input  1  register access request, single cycle
we_i  input  1  1 = write, 0 = read; sampled with req_i
addr_i  input  4  byte address; bits [3:2] select register, [1:0] ignored
wdata_i  input  32  write data
ack_o  output  1  access acknowledge, one cycle after req_i
rdata_o  output  32  read data, valid with ack_o, else 0
irq_o  output  1  level interrupt, registered

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - CMP=CMP_RESET, PERIOD=PERIOD_RESET, CTRL=0, PENDING=0, OVERRUN=0.
  - tick_q=0, ack_o=0, rdata_o=0, irq_o=0.
- Register map:
  - 0x0 TIME: RO, returns time_i; writes ignored.
  - 0x4 CMP: RW, 32-bit.
  - 0x8 PERIOD: RW, 32-bit.
  - 0xC CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN (RW); bit8 PENDING, bit9 OVERRUN (read, write-1-to-clear); other bits read 0.
- Bus timing:
  - Every req_i gets ack_o exactly one cycle later; no wait states, no back-pressure.
  - A write takes effect at the req_i clock edge.
  - A read returns the register value sampled at the req_i edge.
  - A write to CTRL updates EN, PERIODIC and IRQ_EN, and clears PENDING/OVERRUN where wdata bit is 1.
- Evaluation:
  - tick_i is delayed one cycle (tick_q) so comparison sees the incremented time.
  - Match = tick_q & EN & ($signed(time_i - CMP) >= 0). This is wrap-safe and fires immediately if CMP is up to 2^31-1 ms in the past.
  - Evaluation happens only on tick_q cycles; at most one fire per ms.
- On fire:
  - If PENDING already 1 and not being cleared this cycle, set OVERRUN.
  - Set PENDING.
  - One-shot (PERIODIC=0) or PERIOD==0: clear EN.
  - Periodic with PERIOD!=0: CMP <= CMP + PERIOD (mod 2^32), EN stays 1.
- Simultaneous events, all resolved in the same cycle:
  - Fire vs W1C of PENDING: fire wins, PENDING stays 1, OVERRUN not set.
  - Fire vs software CTRL write: software EN/PERIODIC/IRQ_EN values win over the hardware EN clear.
  - Fire vs software CMP write: software CMP wins over the periodic reload.
- irq_o is registered: irq_o <= PENDING_next & IRQ_EN_next. It asserts one cycle after the fire cycle and stays high until PENDING is cleared or IRQ_EN is written 0.
- Reset mid-operation: all state returns to reset values immediately; a pending tick_q is lost.
- No combinational path from any input to any output.

Test Plan:
- Reset, then read all four registers:
  - CTRL=0, CMP=CMP_RESET, PERIOD=PERIOD_RESET, TIME=time_i.
  - ack_o exactly 1 cycle after each req_i; irq_o=0.
- One-shot:
  - Stimulus: CMP=5, CTRL=0x5, drive ticks with time_i 0→5.
  - Required: fire on tick_q when time_i=5; PENDING=1; EN=0; irq_o high the following cycle.
  - Then write CTRL with bit8=1: irq_o drops one cycle later, and no further fires at time_i=6..10.
- Periodic:
  - Stimulus: CMP=10, PERIOD=3, CTRL=0x7, software clears PENDING after each fire.
  - Required: fires at time_i=10, 13, 16; CMP reads 19 after third fire; EN stays 1.
- Overrun:
  - Stimulus: periodic PERIOD=2, PENDING never cleared.
  - Required: second fire sets OVERRUN=1 (CTRL bit9).
  - Writing 0x300|0x7 clears both; irq_o falls.
- Wrap and past compare:
  - CMP=0xFFFF_FFFE, time_i advancing 0xFFFF_FFFD→0x0000_0001: single fire at 0xFFFF_FFFE.
  - Periodic PERIOD=4 from CMP=0xFFFF_FFFE gives next CMP=0x0000_0002.
  - Enabling with CMP=100 while time_i=200 fires on the next tick_q.
- Collisions:
  - W1C of PENDING on the fire cycle: PENDING=1, OVERRUN=0.
  - CTRL write EN=1 PERIODIC=0 on a one-shot fire cycle: EN reads 1 afterward.
  - Async rst_i asserted mid-period with PENDING=1: irq_o=0 and CTRL=0 without waiting for a clock edge.
